// File: rtl/ghost_mover.sv
// Per-ghost motion engine: owns tile/sub-tile position and heading, probes the
// wall ROM at each tile centre, commits a heading and steps on frame ticks.
module ghost_mover #(
    parameter int         TILE      = 12,
    parameter int         STEP      = 1,
    parameter int         MAZE_W    = 28,
    parameter int         MAZE_H    = 31,
    parameter int         START_TX  = 13,
    parameter int         START_TY  = 11,
    parameter logic [3:0] START_DIR = 4'd1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       load,
    input  logic [5:0] load_tx,
    input  logic [5:0] load_ty,
    input  logic [3:0] load_dir,
    input  logic [3:0] nd_in,
    output logic       maze_rd,
    output logic [5:0] maze_tx,
    output logic [5:0] maze_ty,
    input  logic       maze_wall,
    output logic [9:0] ghost_x,
    output logic [9:0] ghost_y,
    output logic [3:0] cur_dir,
    output logic [3:0] avail_dir,
    output logic       busy,
    output logic [3:0] state_dbg
);

    localparam int SW = $clog2(TILE);
    localparam logic [SW-1:0] SUB_STEP = SW'(STEP);
    localparam logic [SW-1:0] SUB_LAST = SW'(TILE - STEP);
    localparam logic [5:0]    TX_LAST  = 6'(MAZE_W - 1);
    localparam logic [5:0]    TY_LAST  = 6'(MAZE_H - 1);
    localparam logic [9:0]    TILE_PX  = 10'(TILE);

    localparam logic [3:0] S_MOVE   = 4'd0;
    localparam logic [3:0] S_Q_L0   = 4'd1;
    localparam logic [3:0] S_Q_L1   = 4'd2;
    localparam logic [3:0] S_Q_U0   = 4'd3;
    localparam logic [3:0] S_Q_U1   = 4'd4;
    localparam logic [3:0] S_Q_R0   = 4'd5;
    localparam logic [3:0] S_Q_R1   = 4'd6;
    localparam logic [3:0] S_Q_D0   = 4'd7;
    localparam logic [3:0] S_Q_D1   = 4'd8;
    localparam logic [3:0] S_DECIDE = 4'd9;

    logic [3:0]    state;
    logic [5:0]    tile_x, tile_y;
    logic [SW-1:0] sub_x, sub_y;

    logic          at_centre;
    logic          up_ok, down_ok;
    logic [5:0]    left_tx, right_tx;
    logic [3:0]    rev_dir;
    logic [3:0]    dec_dir;
    logic          dec_move;
    logic [3:0]    step_dir;
    logic [5:0]    nx_tile_x, nx_tile_y;
    logic [SW-1:0] nx_sub_x, nx_sub_y;

    assign ghost_x   = 10'(tile_x) * TILE_PX + 10'(sub_x);
    assign ghost_y   = 10'(tile_y) * TILE_PX + 10'(sub_y);
    assign busy      = (state != S_MOVE);
    assign state_dbg = state;

    assign at_centre = (sub_x == '0) && (sub_y == '0);
    assign left_tx   = (tile_x == 6'd0) ? TX_LAST : tile_x - 6'd1;
    assign right_tx  = (tile_x >= TX_LAST) ? 6'd0 : tile_x + 6'd1;
    // Rows above 0 and below MAZE_H-1 have no tunnel: those probes are skipped.
    assign up_ok     = (tile_y != 6'd0);
    assign down_ok   = (tile_y < TY_LAST);

    function automatic logic dir_open(input logic [3:0] d, input logic [3:0] av);
        logic r;
        case (d)
            4'd1:    r = av[0];
            4'd2:    r = av[1];
            4'd3:    r = av[2];
            4'd4:    r = av[3];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        case (cur_dir)
            4'd1:    rev_dir = 4'd3;
            4'd2:    rev_dir = 4'd4;
            4'd3:    rev_dir = 4'd1;
            4'd4:    rev_dir = 4'd2;
            default: rev_dir = 4'd0;
        endcase
    end

    // Heading priority: legal proposal, keep going, first open turn, reverse.
    always_comb begin
        dec_dir  = cur_dir;
        dec_move = 1'b0;
        if (dir_open(nd_in, avail_dir) && (nd_in != rev_dir)) begin
            dec_dir  = nd_in;
            dec_move = 1'b1;
        end else if (dir_open(cur_dir, avail_dir)) begin
            dec_move = 1'b1;
        end else begin
            for (int i = 1; i <= 4; i++) begin
                if (!dec_move && (4'(i) != rev_dir) && dir_open(4'(i), avail_dir)) begin
                    dec_dir  = 4'(i);
                    dec_move = 1'b1;
                end
            end
            if (!dec_move && dir_open(rev_dir, avail_dir)) begin
                dec_dir  = rev_dir;
                dec_move = 1'b1;
            end
        end
    end

    assign step_dir = (state == S_DECIDE) ? dec_dir : cur_dir;

    always_comb begin
        nx_tile_x = tile_x;
        nx_tile_y = tile_y;
        nx_sub_x  = sub_x;
        nx_sub_y  = sub_y;
        case (step_dir)
            4'd1: begin
                if (sub_x == '0) begin
                    nx_sub_x  = SUB_LAST;
                    nx_tile_x = left_tx;
                end else begin
                    nx_sub_x = sub_x - SUB_STEP;
                end
            end
            4'd2: begin
                if (sub_y == '0) begin
                    nx_sub_y  = SUB_LAST;
                    nx_tile_y = tile_y - 6'd1;
                end else begin
                    nx_sub_y = sub_y - SUB_STEP;
                end
            end
            4'd3: begin
                if (sub_x == SUB_LAST) begin
                    nx_sub_x  = '0;
                    nx_tile_x = right_tx;
                end else begin
                    nx_sub_x = sub_x + SUB_STEP;
                end
            end
            4'd4: begin
                if (sub_y == SUB_LAST) begin
                    nx_sub_y  = '0;
                    nx_tile_y = tile_y + 6'd1;
                end else begin
                    nx_sub_y = sub_y + SUB_STEP;
                end
            end
            default: ;
        endcase
    end

    // maze_rd is registered so it is high exactly during each Qx0 state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_MOVE;
            tile_x    <= 6'(START_TX);
            tile_y    <= 6'(START_TY);
            sub_x     <= '0;
            sub_y     <= '0;
            cur_dir   <= START_DIR;
            avail_dir <= 4'd0;
            maze_rd   <= 1'b0;
            maze_tx   <= 6'd0;
            maze_ty   <= 6'd0;
        end else if (load) begin
            state     <= S_MOVE;
            tile_x    <= load_tx;
            tile_y    <= load_ty;
            sub_x     <= '0;
            sub_y     <= '0;
            cur_dir   <= load_dir;
            avail_dir <= 4'd0;
            maze_rd   <= 1'b0;
        end else begin
            maze_rd <= 1'b0;
            case (state)
                S_MOVE: begin
                    if (frame_tick) begin
                        if (at_centre) begin
                            state   <= S_Q_L0;
                            maze_rd <= 1'b1;
                            maze_tx <= left_tx;
                            maze_ty <= tile_y;
                        end else begin
                            tile_x <= nx_tile_x;
                            tile_y <= nx_tile_y;
                            sub_x  <= nx_sub_x;
                            sub_y  <= nx_sub_y;
                        end
                    end
                end
                S_Q_L0: state <= S_Q_L1;
                S_Q_L1: begin
                    avail_dir[0] <= ~maze_wall;
                    state        <= S_Q_U0;
                    if (up_ok) begin
                        maze_rd <= 1'b1;
                        maze_tx <= tile_x;
                        maze_ty <= tile_y - 6'd1;
                    end
                end
                S_Q_U0: state <= S_Q_U1;
                S_Q_U1: begin
                    avail_dir[1] <= up_ok & ~maze_wall;
                    state        <= S_Q_R0;
                    maze_rd      <= 1'b1;
                    maze_tx      <= right_tx;
                    maze_ty      <= tile_y;
                end
                S_Q_R0: state <= S_Q_R1;
                S_Q_R1: begin
                    avail_dir[2] <= ~maze_wall;
                    state        <= S_Q_D0;
                    if (down_ok) begin
                        maze_rd <= 1'b1;
                        maze_tx <= tile_x;
                        maze_ty <= tile_y + 6'd1;
                    end
                end
                S_Q_D0: state <= S_Q_D1;
                S_Q_D1: begin
                    avail_dir[3] <= down_ok & ~maze_wall;
                    state        <= S_DECIDE;
                end
                S_DECIDE: begin
                    cur_dir <= dec_dir;
                    if (dec_move) begin
                        tile_x <= nx_tile_x;
                        tile_y <= nx_tile_y;
                        sub_x  <= nx_sub_x;
                        sub_y  <= nx_sub_y;
                    end
                    state <= S_MOVE;
                end
                default: state <= S_MOVE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_mover.sv
// Bench for ghost_mover: a maze array answers ROM reads, and a pixel-level
// model of the ghost predicts position, heading, probes and busy time.
module tb_ghost_mover;

    localparam int TILE = 12;
    localparam int MW   = 28;
    localparam int MH   = 31;
    localparam int PXW  = MW * TILE;

    logic       Clk, Reset, frame_tick, load;
    logic [5:0] load_tx, load_ty;
    logic [3:0] load_dir, nd_in;
    logic       maze_rd, maze_wall, busy;
    logic [5:0] maze_tx, maze_ty;
    logic [9:0] ghost_x, ghost_y;
    logic [3:0] cur_dir, avail_dir, state_dbg;

    ghost_mover dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .load(load),
        .load_tx(load_tx), .load_ty(load_ty), .load_dir(load_dir), .nd_in(nd_in),
        .maze_rd(maze_rd), .maze_tx(maze_tx), .maze_ty(maze_ty), .maze_wall(maze_wall),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .cur_dir(cur_dir), .avail_dir(avail_dir),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // maze wall ROM: answer one cycle after the read strobe, open otherwise
    bit walls [0:MH-1][0:MW-1];
    always @(posedge Clk) begin
        if (maze_rd && maze_ty < 6'(MH) && maze_tx < 6'(MW))
            maze_wall <= walls[maze_ty][maze_tx];
        else
            maze_wall <= 1'b0;
    end

    // read / busy monitor
    int          cyc = 0;
    logic [11:0] rd_q[$];
    int          rd_cyc[$];
    int          busy_cnt;
    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) begin
        if (maze_rd === 1'b1) begin
            rd_q.push_back({maze_ty, maze_tx});
            rd_cyc.push_back(cyc);
        end
        if (busy === 1'b1) busy_cnt++;
    end

    // scoreboard state
    int          checks = 0;
    int          errors = 0;
    int          mx, my, mdir;
    logic [3:0]  mav;
    bit          m_query;
    logic [11:0] exp_q[$];
    int          exp_slot[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic bit is_open(int d, logic [3:0] av);
        return (d >= 1 && d <= 4) ? av[d-1] : 1'b0;
    endfunction

    function automatic int decide(int cur, int nd, logic [3:0] av, output bit mv);
        int rev;
        rev = (cur >= 1 && cur <= 4) ? ((cur + 1) % 4) + 1 : 0;
        mv  = 1'b1;
        if (is_open(nd, av) && nd != rev) return nd;
        if (is_open(cur, av)) return cur;
        for (int d = 1; d <= 4; d++)
            if (d != rev && is_open(d, av)) return d;
        if (is_open(rev, av)) return rev;
        mv = 1'b0;
        return cur;
    endfunction

    task automatic model_step(int d);
        case (d)
            1: mx = (mx + PXW - 1) % PXW;
            2: my = my - 1;
            3: mx = (mx + 1) % PXW;
            4: my = my + 1;
            default: ;
        endcase
    endtask

    task automatic model_tick();
        int tx, ty;
        logic [3:0] av;
        bit mv;
        exp_q.delete();
        exp_slot.delete();
        m_query = 1'b0;
        if (mx % TILE == 0 && my % TILE == 0) begin
            m_query = 1'b1;
            tx = mx / TILE;
            ty = my / TILE;
            av = 4'b0000;
            exp_q.push_back({6'(ty), 6'((tx + MW - 1) % MW)});
            exp_slot.push_back(0);
            av[0] = !walls[ty][(tx + MW - 1) % MW];
            if (ty > 0) begin
                exp_q.push_back({6'(ty - 1), 6'(tx)});
                exp_slot.push_back(1);
                av[1] = !walls[ty-1][tx];
            end
            exp_q.push_back({6'(ty), 6'((tx + 1) % MW)});
            exp_slot.push_back(2);
            av[2] = !walls[ty][(tx + 1) % MW];
            if (ty < MH - 1) begin
                exp_q.push_back({6'(ty + 1), 6'(tx)});
                exp_slot.push_back(3);
                av[3] = !walls[ty+1][tx];
            end
            mav  = av;
            mdir = decide(mdir, int'(nd_in), av, mv);
            if (mv) model_step(mdir);
        end else begin
            model_step(mdir);
        end
    endtask

    // driver tasks (all start and end on a falling edge)
    task automatic clear_walls();
        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++)
                walls[y][x] = 1'b0;
    endtask

    task automatic pulse_tick();
        rd_q.delete();
        rd_cyc.delete();
        busy_cnt   = 0;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_load(int tx, int ty, int d, bit with_tick);
        load_tx    = 6'(tx);
        load_ty    = 6'(ty);
        load_dir   = 4'(d);
        load       = 1'b1;
        frame_tick = with_tick;
        @(negedge Clk);
        load       = 1'b0;
        frame_tick = 1'b0;
        mx = tx * TILE; my = ty * TILE; mdir = d; mav = 4'b0000;
        check("load_x", ghost_x, mx);
        check("load_y", ghost_y, my);
        check("load_dir", cur_dir, mdir);
        check("load_avail", avail_dir, 0);
        check("load_rd", maze_rd, 0);
        check("load_busy", busy, 0);
    endtask

    task automatic settle_and_check(string tag);
        int guard = 0;
        while (busy !== 1'b0 && guard < 40) begin
            @(negedge Clk);
            guard++;
        end
        check({tag, "_idle"}, busy, 0);
        @(negedge Clk);
        check({tag, "_x"}, ghost_x, mx);
        check({tag, "_y"}, ghost_y, my);
        check({tag, "_dir"}, cur_dir, mdir);
        check({tag, "_avail"}, avail_dir, mav);
        check({tag, "_busy_cycles"}, busy_cnt, m_query ? 9 : 0);
        check({tag, "_reads"}, rd_q.size(), exp_q.size());
        if (rd_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                check({tag, "_rd_addr"}, rd_q[i], exp_q[i]);
                if (i > 0)
                    check({tag, "_rd_spacing"}, rd_cyc[i] - rd_cyc[0],
                          2 * (exp_slot[i] - exp_slot[0]));
            end
        end
    endtask

    task automatic tick_check(string tag);
        pulse_tick();
        model_tick();
        settle_and_check(tag);
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; load = 1'b0;
        load_tx = '0; load_ty = '0; load_dir = '0; nd_in = '0;
        busy_cnt = 0;
        clear_walls();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        mx = 156; my = 132; mdir = 1; mav = 4'b0000;

        // reset state
        check("rst_x", ghost_x, 156);
        check("rst_y", ghost_y, 132);
        check("rst_dir", cur_dir, 1);
        check("rst_avail", avail_dir, 0);
        check("rst_rd", maze_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_maze_tx", maze_tx, 0);

        // open crossroads with proposal up
        nd_in = 4'd2;
        tick_check("cross");
        check("cross_avail_lit", avail_dir, 4'b1111);
        check("cross_y_lit", ghost_y, 131);

        // illegal proposal: up/down walled
        walls[10][13] = 1'b1;
        walls[12][13] = 1'b1;
        do_load(13, 11, 1, 1'b0);
        nd_in = 4'd2;
        tick_check("illegal");
        check("illegal_avail_lit", avail_dir, 4'b0101);
        check("illegal_x_lit", ghost_x, 155);

        // dead end: only right open, reverse taken
        walls[11][12] = 1'b1;
        do_load(13, 11, 1, 1'b0);
        nd_in = 4'd1;
        tick_check("dead");
        check("dead_dir_lit", cur_dir, 3);
        tick_check("dead2");
        check("dead2_x_lit", ghost_x, 158);

        // tunnel: leftward wrap from column 0
        clear_walls();
        walls[13][0]  = 1'b1;
        walls[15][0]  = 1'b1;
        walls[13][27] = 1'b1;
        walls[15][27] = 1'b1;
        do_load(0, 14, 1, 1'b0);
        nd_in = 4'd0;
        tick_check("tunnel");
        check("tunnel_x_lit", ghost_x, 335);
        for (int i = 0; i < 11; i++) tick_check("tunnel_run");
        check("tunnel_324_lit", ghost_x, 324);
        tick_check("tunnel_requery");

        // load aborts a query in Q_R0
        clear_walls();
        do_load(13, 11, 1, 1'b0);
        pulse_tick();
        repeat (4) @(negedge Clk);
        check("abort_rd_before", maze_rd, 1);
        check("abort_tx_before", maze_tx, 14);
        do_load(5, 5, 3, 1'b0);
        check("abort_x_lit", ghost_x, 60);

        // tick during busy is dropped
        nd_in = 4'd3;
        pulse_tick();
        model_tick();
        repeat (3) @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        settle_and_check("busy_drop");
        check("busy_drop_x_lit", ghost_x, 61);

        // simultaneous load and tick: tick discarded
        do_load(20, 7, 2, 1'b1);
        @(negedge Clk);
        check("load_tick_busy", busy, 0);
        check("load_tick_y", ghost_y, 84);

        // reset in the middle of a query
        pulse_tick();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        mx = 156; my = 132; mdir = 1; mav = 4'b0000;
        check("midrst_rd", maze_rd, 0);
        check("midrst_busy", busy, 0);
        check("midrst_x", ghost_x, mx);
        check("midrst_y", ghost_y, my);
        check("midrst_dir", cur_dir, mdir);
        check("midrst_avail", avail_dir, 0);

        // randomized walk through a random maze
        for (int y = 0; y < MH; y++)
            for (int x = 0; x < MW; x++)
                walls[y][x] = ($urandom_range(0, 99) < 35);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 29) == 0)
                do_load($urandom_range(0, MW - 1), $urandom_range(0, MH - 1),
                        $urandom_range(1, 4), 1'b0);
            nd_in = 4'($urandom_range(0, 6));
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            tick_check("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghost_mover.md
Name: ghost_mover

Overview:
- Per-ghost motion engine that owns ghost position and heading.
- Drives the position and current direction into the direction-choice logic and consumes the direction it returns.
- At each tile centre it probes the maze wall ROM for the four neighbour tiles, builds the available-direction vector, commits a new heading, then steps the ghost pixel by pixel on frame ticks.
- One instance per ghost; sits between the maze ROM arbiter and the sprite renderer.

Parameters:
- TILE, 12, tile size in pixels.
- STEP, 1, pixels moved per frame tick; must divide TILE.
- MAZE_W, 28, maze width in tiles.
- MAZE_H, 31, maze height in tiles.
- START_TX, 13, reset tile column.
- START_TY, 11, reset tile row.
- START_DIR, 1, reset heading.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- load  in  1  one-cycle pulse: reposition ghost.
- load_tx  in  6  tile column for load.
- load_ty  in  6  tile row for load.
- load_dir  in  4  heading for load.
- nd_in  in  4  proposed direction from direction-choice logic (combinational from ghost_x, ghost_y, cur_dir, avail_dir).
- maze_rd  out  1  wall-ROM read strobe.
- maze_tx  out  6  wall-ROM tile column.
- maze_ty  out  6  wall-ROM tile row.
- maze_wall  in  1  1 = wall; valid exactly one cycle after maze_rd.
- ghost_x  out  10  pixel x (tile_x*TILE + sub_x).
- ghost_y  out  10  pixel y.
- cur_dir  out  4  heading: 1 left, 2 up, 3 right, 4 down.
- avail_dir  out  4  bit0 left, bit1 up, bit2 right, bit3 down; 1 = open.
- busy  out  1  high in QUERY/DECIDE.

Behaviour:
- Reset values:
  - ghost_x = START_TX*TILE (156); ghost_y = START_TY*TILE (132).
  - cur_dir = START_DIR; avail_dir = 0; maze_rd = 0; maze_tx = maze_ty = 0; busy = 0; state MOVE.
- Internal state: tile_x, tile_y and sub_x, sub_y (0..TILE-1). No division is used.
- States:
  - MOVE → Q_L0, Q_L1, Q_U0, Q_U1, Q_R0, Q_R1, Q_D0, Q_D1 → DECIDE → MOVE.
- MOVE, on frame_tick:
  - If sub_x==0 and sub_y==0 (tile centre), go to Q_L0; the tick is held for DECIDE.
  - Otherwise add/subtract STEP along cur_dir, carrying into the tile counter when sub wraps.
  - No tick: hold.
- Qx0 states:
  - Assert maze_rd for one cycle with the neighbour tile.
  - Left: (tile_x-1, tile_y); tile_x=0 wraps to MAZE_W-1.
  - Up: (tile_x, tile_y-1).
  - Right: (tile_x+1, tile_y); tile_x=MAZE_W-1 wraps to 0.
  - Down: (tile_x, tile_y+1).
  - Vertical out-of-range (row -1 or MAZE_H): no read issued, bit forced to 0, the Qx1 state is still spent.
- Qx1 states: maze_rd=0; sample maze_wall and write the inverted value into the corresponding avail_dir bit.
- Query latency is 8 cycles fixed. avail_dir is updated bit by bit and is stable from DECIDE onward.
- DECIDE (one cycle), select heading with priority:
  1. nd_in in 1..4, its avail bit set, and not the reverse of cur_dir.
  2. cur_dir, if its bit is open.
  3. First open non-reverse direction in order left, up, right, down.
  4. Reverse, if open.
  5. None: keep cur_dir and do not move.
- DECIDE then registers cur_dir and applies one STEP in the new heading (the held tick), then returns to MOVE.
- Ticks arriving during QUERY/DECIDE (busy=1) are dropped, not queued.
- Horizontal pixel wrap (tunnel):
  - Stepping left from ghost_x=0 gives ghost_x = MAZE_W*TILE - STEP (335), tile_x = MAZE_W-1.
  - Stepping right past MAZE_W*TILE-1 gives 0.
- Vertical motion never wraps.
- load, in any state, has priority over frame_tick and the FSM:
  - Next cycle: tile = load_tx/load_ty, sub = 0, cur_dir = load_dir, avail_dir = 0, maze_rd = 0, state MOVE.
  - A maze_wall response pending from an aborted read is ignored.
- Reset mid-query: same as reset; maze_rd is low the following cycle.
- Simultaneous load and frame_tick: load wins and the tick is discarded.

Test Plan:
- Reset → ghost_x=156, ghost_y=132, cur_dir=1, avail_dir=0, maze_rd=0, busy=0.
- Open crossroads at (13,11):
  - Stimulus: all walls 0, frame_tick.
  - maze_rd pulses 4 times at (12,11), (13,10), (14,11), (13,12), one cycle apart by two.
  - Then avail_dir=1111; with nd_in=2, cur_dir=2 and ghost_y=131 after DECIDE; busy high for 9 cycles.
- Illegal proposal:
  - Stimulus: up/down walls, cur_dir=1, nd_in=2.
  - avail_dir=0101; cur_dir stays 1; ghost_x=155.
- Dead end:
  - Stimulus: only right open, cur_dir=1, nd_in=1.
  - cur_dir=3 (reverse taken); ghost_x advances by 1 per tick.
- Tunnel:
  - Stimulus: load (0,14,dir 1), left open, tick.
  - Left probe at maze_tx=27; ghost_x=335, tile_x=27.
  - 11 further ticks reach ghost_x=324 with no query; the 12th tick triggers a query.
- Abort and busy:
  - load asserted in Q_R0 → maze_rd=0 next cycle, busy=0, position = load tile*12.
  - A frame_tick during busy produces no movement.
